// File: rtl/fcc_pkg.sv
// Shared types and default sizing for the frame capture controller.
package fcc_pkg;

    localparam int unsigned ADDR_W_DEF       = 17;
    localparam int unsigned FRAME_PIXELS_DEF = 76800;
    localparam int unsigned CNT_W_DEF        = 8;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StArmed   = 2'd1,
        StCapture = 2'd2
    } state_e;

    typedef logic bank_t;

endpackage

// File: rtl/frame_capture_ctrl_if.sv
// Frame-store bus: BRAM write port toward the frame memory plus the
// publish/release handshake toward the Ethernet TX reader.
interface frame_capture_ctrl_if
    import fcc_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
);
    logic              bram_we;
    logic [ADDR_W:0]   bram_waddr;
    logic [23:0]       bram_wdata;
    logic              frame_valid;
    bank_t             rd_bank;
    logic              rd_done;
    logic [CNT_W-1:0]  frame_seq;

    modport master (
        output bram_we, bram_waddr, bram_wdata, frame_valid, rd_bank, frame_seq,
        input  rd_done
    );

    modport slave (
        input  bram_we, bram_waddr, bram_wdata, frame_valid, rd_bank, frame_seq,
        output rd_done
    );
endinterface

// File: rtl/fcc_bank_alloc.sv
// Ping-pong bank bookkeeping: full flags, per-bank frame tags, oldest-bank
// publishing to the reader, and the free-bank choice for a starting frame.
module fcc_bank_alloc
    import fcc_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             complete,
    input  bank_t            cmp_bank,
    input  logic [CNT_W-1:0] cmp_tag,
    input  logic             start,
    input  bank_t            wr_bank,
    input  logic             rd_done,
    output logic             free_any,
    output bank_t            free_bank,
    output logic             frame_valid,
    output bank_t            rd_bank,
    output logic [CNT_W-1:0] frame_seq
);
    logic [1:0]       full_q, full_n;
    logic [CNT_W-1:0] tag_q [2];
    bank_t            last_q, last_n, oldest_q, rd_bank_q, pub, pref, nxt_wr;
    logic             fv_q, rel;
    logic [CNT_W-1:0] seq_q;

    assign rel = rd_done & fv_q;

    // Release and completion land before the free check so a same-cycle
    // frame start sees the bank just freed and never the one just filled.
    always_comb begin
        full_n = full_q;
        last_n = last_q;
        if (rel) full_n[rd_bank_q] = 1'b0;
        if (complete) begin
            full_n[cmp_bank] = 1'b1;
            last_n           = cmp_bank;
        end
        pref      = ~last_n;
        free_any  = ~&full_n;
        free_bank = full_n[pref] ? ~pref : pref;
        nxt_wr    = (start && free_any) ? free_bank : wr_bank;
        pub       = (&full_q) ? oldest_q : full_q[1];
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            full_q    <= 2'b00;
            tag_q[0]  <= '0;
            tag_q[1]  <= '0;
            last_q    <= 1'b1;
            oldest_q  <= 1'b0;
            fv_q      <= 1'b0;
            rd_bank_q <= 1'b0;
            seq_q     <= '0;
        end else begin
            full_q <= full_n;
            last_q <= last_n;
            if (complete) begin
                tag_q[cmp_bank] <= cmp_tag;
                if (!full_n[~cmp_bank]) oldest_q <= cmp_bank;
            end
            if (fv_q && !rd_done) begin
                fv_q <= 1'b1;
            end else if (!fv_q && (|full_q)) begin
                fv_q      <= 1'b1;
                rd_bank_q <= pub;
                seq_q     <= tag_q[pub];
            end else begin
                fv_q <= 1'b0;
                // Steer the idle pointer off the bank about to be written.
                if (nxt_wr == rd_bank_q) rd_bank_q <= ~nxt_wr;
            end
        end
    end

    assign frame_valid = fv_q;
    assign rd_bank     = rd_bank_q;
    assign frame_seq   = seq_q;

endmodule

// File: rtl/frame_capture_ctrl.sv
// Captures downscaled pixels into a ping-pong BRAM frame store and hands full
// frames to the reader. Optional FCC_TESTPAT_EN replaces pixel data with a pattern.
module frame_capture_ctrl
    import fcc_pkg::*;
#(
    parameter int unsigned ADDR_W       = ADDR_W_DEF,
    parameter int unsigned FRAME_PIXELS = FRAME_PIXELS_DEF,
    parameter bit          VSYNC_POL    = 1'b1,
    parameter int unsigned CNT_W        = CNT_W_DEF
) (
    input  logic                 pclk,
    input  logic                 rst,
    input  logic                 cap_en,
    input  logic                 i_vsync,
    input  logic                 i_ena,
    input  logic [23:0]          i_rgb,
    frame_capture_ctrl_if.master bus,
    output logic [CNT_W-1:0]     drop_cnt,
    output logic [CNT_W-1:0]     short_cnt,
    output logic                 busy
);
    localparam int unsigned PW = ADDR_W + 1;
    localparam logic [PW-1:0] FP = PW'(FRAME_PIXELS);

    state_e           state_q, state_d;
    bank_t            wr_bank_q, wr_bank_d, free_bank;
    logic [PW-1:0]    pix_cnt_q, pix_cnt_d;
    logic             ovl_q, ovl_d;
    logic [CNT_W-1:0] seq_q, seq_d, drop_q, drop_d, short_q, short_d;
    logic             vs_q, fb_q, act, in_cap, good, complete, start_try, px_acc;
    logic             free_any, we_q;
    logic [ADDR_W:0]  waddr_q;
    logic [23:0]      wdata_q, wdata_n;

    assign act       = (i_vsync == VSYNC_POL);
    assign in_cap    = (state_q == StCapture);
    assign good      = (pix_cnt_q == FP) && !ovl_q;
    assign complete  = in_cap && fb_q && good;
    assign start_try = fb_q && cap_en && (state_q == StArmed || in_cap);
    // Pixels arriving on the boundary cycle belong to neither frame.
    assign px_acc    = in_cap && !fb_q && i_ena && (pix_cnt_q < FP);

    fcc_bank_alloc #(
        .CNT_W (CNT_W)
    ) u_alloc (
        .pclk        (pclk),
        .rst         (rst),
        .complete    (complete),
        .cmp_bank    (wr_bank_q),
        .cmp_tag     (seq_q),
        .start       (start_try),
        .wr_bank     (wr_bank_q),
        .rd_done     (bus.rd_done),
        .free_any    (free_any),
        .free_bank   (free_bank),
        .frame_valid (bus.frame_valid),
        .rd_bank     (bus.rd_bank),
        .frame_seq   (bus.frame_seq)
    );

    always_comb begin
        state_d   = state_q;
        wr_bank_d = wr_bank_q;
        pix_cnt_d = pix_cnt_q;
        ovl_d     = ovl_q;
        seq_d     = seq_q;
        drop_d    = drop_q;
        short_d   = short_q;
        unique case (state_q)
            StIdle:  if (cap_en) state_d = StArmed;
            StArmed: if (!cap_en) state_d = StIdle;
            StCapture: begin
                if (fb_q) begin
                    if (good) seq_d = seq_q + 1'b1;
                    else if (short_q != '1) short_d = short_q + 1'b1;
                    if (!cap_en) state_d = StIdle;
                end else if (i_ena) begin
                    if (pix_cnt_q < FP) pix_cnt_d = pix_cnt_q + 1'b1;
                    else ovl_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        if (start_try) begin
            if (free_any) begin
                wr_bank_d = free_bank;
                pix_cnt_d = '0;
                ovl_d     = 1'b0;
                state_d   = StCapture;
            end else begin
                state_d = StArmed;
                if (drop_q != '1) drop_d = drop_q + 1'b1;
            end
        end
    end

`ifdef FCC_TESTPAT_EN
    logic [31:0] pc32, tg32;
    always_comb begin
        pc32    = 32'(pix_cnt_q);
        tg32    = 32'(seq_q);
        wdata_n = {pc32[7:0], ~pc32[7:0], tg32[7:0]};
    end
`else
    always_comb begin
        wdata_n = i_rgb;
    end
`endif

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q   <= StIdle;
            wr_bank_q <= 1'b0;
            pix_cnt_q <= '0;
            ovl_q     <= 1'b0;
            seq_q     <= '0;
            drop_q    <= '0;
            short_q   <= '0;
            vs_q      <= 1'b0;
            fb_q      <= 1'b0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            wr_bank_q <= wr_bank_d;
            pix_cnt_q <= pix_cnt_d;
            ovl_q     <= ovl_d;
            seq_q     <= seq_d;
            drop_q    <= drop_d;
            short_q   <= short_d;
            vs_q      <= act;
            fb_q      <= act && !vs_q;
            we_q      <= px_acc;
            if (px_acc) begin
                waddr_q <= {wr_bank_q, pix_cnt_q[ADDR_W-1:0]};
                wdata_q <= wdata_n;
            end
        end
    end

    assign bus.bram_we    = we_q;
    assign bus.bram_waddr = waddr_q;
    assign bus.bram_wdata = wdata_q;
    assign drop_cnt       = drop_q;
    assign short_cnt      = short_q;
    assign busy           = in_cap;

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Directed bench for frame_capture_ctrl with a 16-pixel frame so that the
// multi-frame scenarios stay short.
module tb_frame_capture_ctrl;
    import fcc_pkg::*;

    localparam int unsigned AW = 5;
    localparam int unsigned FP = 16;
    localparam int unsigned CW = 8;

    logic          pclk;
    logic          rst;
    logic          cap_en;
    logic          i_vsync;
    logic          i_ena;
    logic [23:0]   i_rgb;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] short_cnt;
    logic          busy;

    frame_capture_ctrl_if #(.ADDR_W(AW), .CNT_W(CW)) bus ();

    frame_capture_ctrl #(
        .ADDR_W       (AW),
        .FRAME_PIXELS (FP),
        .VSYNC_POL    (1'b1),
        .CNT_W        (CW)
    ) dut (
        .pclk      (pclk),
        .rst       (rst),
        .cap_en    (cap_en),
        .i_vsync   (i_vsync),
        .i_ena     (i_ena),
        .i_rgb     (i_rgb),
        .bus       (bus.master),
        .drop_cnt  (drop_cnt),
        .short_cnt (short_cnt),
        .busy      (busy)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int          total = 0;
    int          bad   = 0;
    int          wr_cnt = 0;
    int          b0_cnt = 0;
    int          b1_cnt = 0;
    int          hi_idx = 0;
    logic [31:0] last_addr = '0;
    logic [31:0] last_data = '0;

    // Record every committed BRAM write.
    always @(posedge pclk) begin
        if (bus.bram_we === 1'b1) begin
            wr_cnt    <= wr_cnt + 1;
            last_addr <= 32'(bus.bram_waddr);
            last_data <= 32'(bus.bram_wdata);
            if (bus.bram_waddr[AW]) b1_cnt <= b1_cnt + 1;
            else b0_cnt <= b0_cnt + 1;
            if (32'(bus.bram_waddr[AW-1:0]) >= FP) hi_idx <= hi_idx + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        @(negedge pclk);
    endtask

    task automatic fb_event();
        i_vsync = 1'b1;
        tick();
        i_vsync = 1'b0;
        tick();
    endtask

    task automatic pixels(input int n, input logic [7:0] tag);
        for (int i = 0; i < n; i++) begin
            i_ena = 1'b1;
            i_rgb = {tag, 16'(i)};
            tick();
        end
        i_ena = 1'b0;
    endtask

    task automatic release_frame();
        bus.rd_done = 1'b1;
        tick();
        bus.rd_done = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_we"},    32'(bus.bram_we), 32'd0);
        chk({tag, "_waddr"}, 32'(bus.bram_waddr), 32'd0);
        chk({tag, "_wdata"}, 32'(bus.bram_wdata), 32'd0);
        chk({tag, "_fv"},    32'(bus.frame_valid), 32'd0);
        chk({tag, "_rdb"},   32'(bus.rd_bank), 32'd0);
        chk({tag, "_seq"},   32'(bus.frame_seq), 32'd0);
        chk({tag, "_drop"},  32'(drop_cnt), 32'd0);
        chk({tag, "_short"}, 32'(short_cnt), 32'd0);
        chk({tag, "_busy"},  32'(busy), 32'd0);
    endtask

    int snap_wr, snap_b0, snap_hi;

    initial begin
        rst = 1'b1; cap_en = 1'b0; i_vsync = 1'b0; i_ena = 1'b0; i_rgb = '0;
        bus.rd_done = 1'b0;
        tick();
        tick();
        chk_all_zero("reset");
        rst = 1'b0;

        // Two good frames, slow reader.
        cap_en = 1'b1;
        tick();
        fb_event();
        chk("t1_busy", 32'(busy), 32'd1);
        pixels(16, 8'h00);
        fb_event();
        chk("t1_f0_writes", 32'(b0_cnt), 32'd16);
        chk("t1_f0_lastaddr", last_addr, 32'd15);
        chk("t1_f0_lastdata", last_data, 32'h00000f);
        pixels(16, 8'h01);
        chk("t1_fv", 32'(bus.frame_valid), 32'd1);
        chk("t1_rdb0", 32'(bus.rd_bank), 32'd0);
        chk("t1_seq0", 32'(bus.frame_seq), 32'd0);
        cap_en = 1'b0;
        fb_event();
        chk("t1_f1_writes", 32'(b1_cnt), 32'd16);
        chk("t1_f1_lastaddr", last_addr, 32'd47);
        chk("t1_idle", 32'(busy), 32'd0);
        chk("t1_nodrop", 32'(drop_cnt), 32'd0);
        release_frame();
        chk("t1_gap", 32'(bus.frame_valid), 32'd0);
        tick();
        chk("t1_fv2", 32'(bus.frame_valid), 32'd1);
        chk("t1_rdb1", 32'(bus.rd_bank), 32'd1);
        chk("t1_seq1", 32'(bus.frame_seq), 32'd1);
        release_frame();
        tick();
        chk("t1_empty", 32'(bus.frame_valid), 32'd0);

        // Three frames with no release: third is dropped.
        cap_en = 1'b1;
        tick();
        fb_event();
        pixels(16, 8'h02);
        fb_event();
        pixels(16, 8'h03);
        fb_event();
        chk("t2_drop", 32'(drop_cnt), 32'd1);
        chk("t2_armed", 32'(busy), 32'd0);
        snap_wr = wr_cnt;
        pixels(16, 8'h04);
        tick();
        chk("t2_nowrite", 32'(wr_cnt - snap_wr), 32'd0);
        chk("t2_rdb", 32'(bus.rd_bank), 32'd0);
        chk("t2_seq", 32'(bus.frame_seq), 32'd2);
        cap_en = 1'b0;
        tick();
        release_frame();
        tick();
        chk("t2_rdb_next", 32'(bus.rd_bank), 32'd1);
        chk("t2_seq_next", 32'(bus.frame_seq), 32'd3);
        release_frame();
        tick();

        // Short frame, then a good frame reusing bank 0.
        cap_en = 1'b1;
        tick();
        fb_event();
        pixels(15, 8'h05);
        fb_event();
        chk("t3_short", 32'(short_cnt), 32'd1);
        chk("t3_busy", 32'(busy), 32'd1);
        tick();
        chk("t3_nofv", 32'(bus.frame_valid), 32'd0);
        snap_b0 = b0_cnt;
        pixels(16, 8'h06);
        cap_en = 1'b0;
        fb_event();
        chk("t3_reuse_writes", 32'(b0_cnt - snap_b0), 32'd16);
        chk("t3_reuse_addr", last_addr, 32'd15);
        tick();
        chk("t3_rdb", 32'(bus.rd_bank), 32'd0);
        chk("t3_seq", 32'(bus.frame_seq), 32'd4);
        release_frame();
        tick();

        // Overlong frame: 17th pixel is not written.
        cap_en = 1'b1;
        tick();
        fb_event();
        snap_wr = wr_cnt;
        snap_hi = hi_idx;
        pixels(17, 8'h07);
        cap_en = 1'b0;
        fb_event();
        chk("t4_writes", 32'(wr_cnt - snap_wr), 32'd16);
        chk("t4_hi_idx", 32'(hi_idx - snap_hi), 32'd0);
        chk("t4_lastaddr", last_addr, 32'd47);
        chk("t4_short", 32'(short_cnt), 32'd2);
        tick();
        chk("t4_nofv", 32'(bus.frame_valid), 32'd0);

        // Release coinciding with frame end into the other bank.
        cap_en = 1'b1;
        tick();
        fb_event();
        pixels(16, 8'h08);
        fb_event();
        pixels(16, 8'h09);
        chk("t5_fv", 32'(bus.frame_valid), 32'd1);
        chk("t5_rdb", 32'(bus.rd_bank), 32'd1);
        chk("t5_seq", 32'(bus.frame_seq), 32'd5);
        i_vsync = 1'b1;
        tick();
        i_vsync = 1'b0;
        bus.rd_done = 1'b1;
        tick();
        bus.rd_done = 1'b0;
        chk("t5_gap", 32'(bus.frame_valid), 32'd0);
        chk("t5_busy", 32'(busy), 32'd1);
        tick();
        chk("t5_fv2", 32'(bus.frame_valid), 32'd1);
        chk("t5_rdb2", 32'(bus.rd_bank), 32'd0);
        chk("t5_seq2", 32'(bus.frame_seq), 32'd6);
        pixels(3, 8'h0a);
        tick();
        chk("t5_newbank", last_addr, 32'd34);

        // Reset in the middle of a capture.
        pixels(5, 8'h0b);
        rst = 1'b1;
        tick();
        chk_all_zero("t6");
        rst = 1'b0;
        tick();
        fb_event();
        chk("t6_busy", 32'(busy), 32'd1);
        pixels(1, 8'h0c);
        tick();
        chk("t6_addr", last_addr, 32'd0);
        chk("t6_data", last_data, 32'h0c0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/frame_capture_ctrl.md
Name: frame_capture_ctrl

Overview:
Sequences capture of downscaled pixels from rgb2bram into a double-buffered (ping-pong) BRAM frame store, and hands completed frames to the Ethernet TX reader.
- Owns bank allocation, write addressing and per-frame pixel counting.
- Runs the publish/release handshake with the reader.
- Sits between rgb2bram (enout/rgb) and the frame BRAM, in the pixel-clock domain of hdmi_top.

Parameters:
ADDR_W, 17, pixel address width per bank (2**ADDR_W >= FRAME_PIXELS)
FRAME_PIXELS, 76800, pixels per complete frame (320x240)
VSYNC_POL, 1, active level of i_vsync (1 = active-high)
CNT_W, 8, width of statistics counters

Ports:
pclk  in  1  pixel clock; sole clock
rst  in  1  synchronous reset, active-high
cap_en  in  1  capture enable (level)
i_vsync  in  1  vsync from dvi2rgb
i_ena  in  1  pixel valid from rgb2bram
i_rgb  in  24  {r,g,b} pixel
bram_we  out  1  BRAM write enable
bram_waddr  out  ADDR_W+1  {bank, pixel index}
bram_wdata  out  24  pixel data
frame_valid  out  1  a completed frame is owned by the reader
rd_bank  out  1  bank the reader owns (valid while frame_valid)
rd_done  in  1  one-cycle pulse: reader finished rd_bank
frame_seq  out  CNT_W  sequence number of the frame on rd_bank
drop_cnt  out  CNT_W  frames skipped because no bank was free (saturating)
short_cnt  out  CNT_W  frames discarded because the pixel count was wrong (saturating)
busy  out  1  state == CAPTURE

Behaviour:
Frame boundary (fb):
- Rising edge into the active level of i_vsync, detected on a 1-cycle registered copy.
- fb is therefore 1 cycle after the pin transition.

Reset:
- All outputs 0; bank_full = 2'b00; state IDLE; wr_bank = 0; pix_cnt = 0; seq counter = 0.

State machine:
- IDLE: cap_en=1 -> ARMED.
- ARMED: cap_en=0 -> IDLE. On fb:
  - If a bank is free, select it, clear pix_cnt, go to CAPTURE.
  - Bank selection: prefer the bank not last written; otherwise the single free one.
  - If both banks are full: drop_cnt++ (saturating), stay ARMED.
- CAPTURE: each i_ena cycle with pix_cnt < FRAME_PIXELS:
  - bram_we=1 next cycle, bram_waddr = {wr_bank, pix_cnt}, bram_wdata = i_rgb (1-cycle registered latency).
  - pix_cnt++.
  - i_ena with pix_cnt == FRAME_PIXELS: ignored, no write; frame flagged overlong.
- CAPTURE, on fb: frame end.
  - pix_cnt == FRAME_PIXELS and not overlong: bank_full[wr_bank]=1; frame tagged with seq counter, seq counter++.
  - Otherwise: short_cnt++ (saturating), bank left free.
  - Then in the same cycle the frame-start logic runs exactly as in ARMED, so back-to-back frames are captured.
  - If cap_en=0 at that fb: go to IDLE instead.
- cap_en deasserted mid-CAPTURE: the current frame finishes normally at the next fb.

Publish/release:
- frame_valid=0 and some bank full:
  - Next cycle frame_valid=1, rd_bank = oldest full bank, frame_seq = its tag.
- rd_done while frame_valid=1:
  - bank_full[rd_bank]=0 and frame_valid=0.
  - If the other bank is full, it is presented on the following cycle. This gives a 1-cycle gap; frame_valid must never stay high across a bank change.
- rd_done while frame_valid=0: ignored.
- rd_done and a frame completion in the same cycle: both take effect.
- A freed bank is available to a fb occurring in the same cycle.

Invariants:
- Never write to a bank with bank_full=1.
- rd_bank is never the write bank while in CAPTURE.

Reset mid-frame:
- Discards everything; the reader must treat frame_valid falling without rd_done as abort.

Optional Feature:
FCC_TESTPAT_EN
- Defined: bram_wdata = {pix_cnt[7:0], ~pix_cnt[7:0], frame tag[7:0]} instead of i_rgb. Timing and handshake are unchanged. Used for Ethernet link bring-up against a known pattern.
- Undefined: bram_wdata = registered i_rgb.

Decomposition:
- Shared package fcc_pkg:
  - state enum (IDLE, ARMED, CAPTURE)
  - default ADDR_W, FRAME_PIXELS and CNT_W constants
  - bank index typedef
- One natural sub-module: fcc_bank_alloc. It holds bank_full, the per-bank tags and the oldest-bank selection, and produces the free/publish decisions combinationally from state.

Test Plan:
1. cap_en=1, two frames of exactly 76800 i_ena pulses, reader slow -> bank0 then bank1 written; frame_valid=1 with rd_bank=0, frame_seq=0; after rd_done, 1-cycle gap, then rd_bank=1, frame_seq=1.
2. Three full frames with no rd_done -> frames 0 and 1 fill the banks; the third fb sees both full, drop_cnt=1, no bram_we during frame 3.
3. Frame of 76799 pixels -> short_cnt=1, no bank marked full, frame_valid stays 0; next good frame reuses the same bank.
4. Frame of 76801 pixels -> last pixel not written (no bram_we at pix index 76800), short_cnt=1.
5. rd_done in the same cycle as a frame-end fb completing into the other bank -> bank released, new frame marked full, presented 1 cycle later; a new capture starts on the released bank.
6. rst asserted mid-CAPTURE at pix_cnt=1000 -> next cycle all outputs 0; a subsequent fb with cap_en=1 starts capture at bank0, address 0.
